// File: rtl/parity_check_arbiter_if.sv
// Bundle between the requesters, the shared parity checker and the arbiter.
// master = requester/checker side, slave = arbiter side.
interface parity_check_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_parity;
  logic [NREQ-1:0]   req_mode;

  logic [3:0]        chk_data;
  logic              chk_parity;
  logic              chk_mode;
  logic              chk_error;

  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_error;

  modport master (
    output req_valid, req_data, req_parity, req_mode, chk_error,
    input  req_ready, chk_data, chk_parity, chk_mode,
    input  rsp_valid, rsp_id, rsp_error
  );

  modport slave (
    input  req_valid, req_data, req_parity, req_mode, chk_error,
    output req_ready, chk_data, chk_parity, chk_mode,
    output rsp_valid, rsp_id, rsp_error
  );
endinterface

// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sharing one combinational parity checker among NREQ
// requesters; returns a tagged one-cycle response and counts detected errors.
module parity_check_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  parity_check_arbiter_if.slave  bus,
  input  logic                   clr_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CHECK = 1'b1;

  logic [0:0]      state;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  grant_id;

  logic [3:0]      op_data;
  logic            op_parity;
  logic            op_mode;

  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic            rsp_error_q;

  logic            win_found;
  logic [IDW-1:0]  winner;
  logic [3:0]      win_data;
  logic            win_parity;
  logic            win_mode;

  // Search begins just after the last grant and wraps, so every valid
  // requester is reached within NREQ grants.
  // NOTE: every signal written here gets a default first, otherwise the
  // paths where no requester matches would infer latches.
  always_comb begin
    int idx;
    win_found  = 1'b0;
    winner     = '0;
    win_data   = '0;
    win_parity = 1'b0;
    win_mode   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!win_found && bus.req_valid[idx]) begin
        win_found  = 1'b1;
        winner     = IDW'(idx);
        win_data   = bus.req_data[4*idx +: 4];
        win_parity = bus.req_parity[idx];
        win_mode   = bus.req_mode[idx];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (!rst && state == S_IDLE && win_found)
      bus.req_ready = NREQ'(1) << winner;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      last_grant  <= IDW'(NREQ - 1);
      grant_id    <= '0;
      op_data     <= '0;
      op_parity   <= 1'b0;
      op_mode     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            op_data    <= win_data;
            op_parity  <= win_parity;
            op_mode    <= win_mode;
            grant_id   <= winner;
            last_grant <= winner;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= grant_id;
          rsp_error_q <= bus.chk_error;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Clear wins over a simultaneous increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt)
      err_cnt <= '0;
    else if (state == S_CHECK && bus.chk_error && err_cnt != {CNT_W{1'b1}})
      err_cnt <= err_cnt + 1'b1;
  end

  // Operands keep driving the checker in IDLE so its output stays stable.
  assign bus.chk_data   = op_data;
  assign bus.chk_parity = op_parity;
  assign bus.chk_mode   = op_mode;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_error  = rsp_error_q;
  assign busy           = (state == S_CHECK);

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Directed bench for parity_check_arbiter; a second instance with a 2-bit
// counter runs in lockstep on the same stimulus to exercise saturation.
module tb_parity_check_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  logic clr_cnt;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_parity;
  logic [NREQ-1:0]   req_mode;
  logic [7:0]        err_cnt;
  logic [1:0]        err_cnt2;
  logic              busy;
  logic              busy2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  parity_check_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus  ();
  parity_check_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus2 ();

  assign bus.req_valid   = req_valid;
  assign bus.req_data    = req_data;
  assign bus.req_parity  = req_parity;
  assign bus.req_mode    = req_mode;
  assign bus.chk_error   = ^bus.chk_data ^ bus.chk_parity ^ bus.chk_mode;
  assign bus2.req_valid  = req_valid;
  assign bus2.req_data   = req_data;
  assign bus2.req_parity = req_parity;
  assign bus2.req_mode   = req_mode;
  assign bus2.chk_error  = ^bus2.chk_data ^ bus2.chk_parity ^ bus2.chk_mode;

  parity_check_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clr_cnt(clr_cnt),
    .err_cnt(err_cnt), .busy(busy)
  );

  parity_check_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .clr_cnt(clr_cnt),
    .err_cnt(err_cnt2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction from requester id; leaves time at the response cycle.
  task automatic do_req(input int id, input logic [3:0] d, input logic p, input logic m,
                        input logic exp_err, input int exp_cnt, input int exp_cnt2,
                        input logic clr, input string tag);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_valid[id]        = 1'b1;
    req_data[4*id +: 4]  = d;
    req_parity[id]       = p;
    req_mode[id]         = m;
    @(negedge clk);
    while (!bus.req_ready[id] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(1) << id);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    clr_cnt       = clr;
    @(negedge clk);
    check({tag, "_busy"},     32'(busy), 1);
    check({tag, "_chk_data"}, 32'(bus.chk_data), 32'(d));
    check({tag, "_chk_pm"},   {30'd0, bus.chk_parity, bus.chk_mode}, {30'd0, p, m});
    check({tag, "_no_rsp"},   32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 1);
    check({tag, "_rsp_id"},    32'(bus.rsp_id), 32'(id));
    check({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'(exp_err));
    check({tag, "_err_cnt"},   32'(err_cnt), 32'(exp_cnt));
    check({tag, "_err_cnt2"},  32'(err_cnt2), 32'(exp_cnt2));
    check({tag, "_chk_hold"},  32'(bus.chk_data), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ids [16];
    int cyc [16];
    int nrsp;
    int n;

    // Reset with every requester valid.
    rst        = 1'b1;
    clr_cnt    = 1'b0;
    req_valid  = '1;
    req_data   = '0;
    req_parity = '0;
    req_mode   = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready",     32'(bus.req_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_id",    32'(bus.rsp_id), 0);
    check("rst_err_cnt",   32'(err_cnt), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_chk",       {26'd0, bus.chk_data, bus.chk_parity, bus.chk_mode}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("first_grant", 32'(bus.req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("first_busy", 32'(busy), 1);
    @(negedge clk);
    check("first_rsp_valid", 32'(bus.rsp_valid), 1);
    check("first_rsp_id",    32'(bus.rsp_id), 0);

    // Single clean request, then the two error cases.
    do_req(2, 4'b0001, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, "single");
    do_req(1, 4'b0001, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0, "err_even");
    do_req(1, 4'b0000, 1'b0, 1'b1, 1'b1, 2, 2, 1'b0, "err_odd");

    // Standalone clear, then saturation in the 2-bit instance.
    @(posedge clk); #1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    check("clr_cnt",  32'(err_cnt), 0);
    check("clr_cnt2", 32'(err_cnt2), 0);
    for (int k = 1; k <= 5; k++)
      do_req(0, 4'b1000, 1'b0, 1'b0, 1'b1, k, (k > 3) ? 3 : k, 1'b0, "sat");
    do_req(0, 4'b1000, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, "clr_vs_inc");
    do_req(3, 4'b1011, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0, "post_clr");

    // Reset while in CHECK with an erroring transaction.
    n = 0;
    @(posedge clk); #1;
    req_valid[2]    = 1'b1;
    req_data[11:8]  = 4'b0110;
    req_parity[2]   = 1'b1;
    req_mode[2]     = 1'b0;
    @(negedge clk);
    while (!bus.req_ready[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_ready", 32'(bus.req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    req_data   = '0;
    req_parity = '0;
    req_mode   = '0;
    req_valid  = '1;
    @(negedge clk);
    check("mid_no_rsp",  32'(bus.rsp_valid), 0);
    check("mid_busy0",   32'(busy), 0);
    check("mid_err_cnt", 32'(err_cnt), 0);
    check("mid_grant0",  32'(bus.req_ready), 32'b0001);

    // Fairness: all requesters held valid.
    nrsp = 0;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      check("fair_onehot0", 32'($onehot0(bus.req_ready)), 1);
      if (bus.rsp_valid === 1'b1 && nrsp < 16) begin
        ids[nrsp] = int'(bus.rsp_id);
        cyc[nrsp] = c;
        nrsp++;
      end
    end
    req_valid = '0;
    check("fair_count", 32'(nrsp), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < nrsp) begin
        check("fair_id",    32'(ids[i]), 32'(i % 4));
        check("fair_cycle", 32'(cyc[i]), 32'(2 + 2*i));
      end
    end
    repeat (3) @(negedge clk);
    check("fair_err_cnt", 32'(err_cnt), 0);
    check("idle_busy",    32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/parity_check_arbiter.md
# parity_check_arbiter

Controller that shares one combinational 4-bit parity checker among NREQ requesters. It accepts check requests with a valid/ready handshake and arbitrates among them round-robin. It drives the winner's operands into the shared checker, samples the checker's error flag, and returns a tagged one-cycle response. It also keeps a saturating count of detected parity errors. It sits between the requesting datapath ports and the single `parity_checker` instance.

## Interface
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-id width, equal to clog2(NREQ).
- CNT_W, 8, width of the error counter.

- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept. It is combinational, one-hot, and high only in IDLE for the winner.
- req_data  in  4*NREQ  nibble per requester; requester i uses bits [4i+3:4i].
- req_parity  in  NREQ  received parity bit per requester.
- req_mode  in  NREQ  per requester; 0 = even parity, 1 = odd parity.
- chk_data  out  4  operand to the shared checker's data_in.
- chk_parity  out  1  operand to the checker's parity_bit.
- chk_mode  out  1  operand to the checker's mode.
- chk_error  in  1  checker's error output (combinational from chk_*).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  IDW  requester index of the response.
- rsp_error  out  1  parity error flag of the response.
- err_cnt  out  CNT_W  count of responses with rsp_error=1; saturating.
- clr_cnt  in  1  synchronous clear of err_cnt.
- busy  out  1  high while in CHECK.

## Operation
- Checker semantics, for reference values: error = ^data ^ parity ^ mode. Mode 0 errors when the total XOR is 1; mode 1 errors when the total XOR is 0.
- FSM states:
  - IDLE, the reset state.
  - CHECK.
- IDLE:
  - If any req_valid is high, pick a winner round-robin and assert req_ready[winner].
  - On the edge, the handshake completes. Latch the winner's data, parity and mode into the operand registers, latch grant_id <= winner, set last_grant <= winner, and go to CHECK.
  - If no request is pending, stay in IDLE with req_ready = 0.
- CHECK:
  - The operand registers drive chk_*, and req_ready is 0.
  - On the edge: rsp_valid <= 1, rsp_id <= grant_id, rsp_error <= chk_error. If chk_error=1, err_cnt increments. Return to IDLE.
- rsp_valid is low on every other cycle. There is no response backpressure; the consumer must take the response in that cycle.
- Round-robin:
  - Search starts at (last_grant+1) mod NREQ and wraps.
  - last_grant resets to NREQ-1, so requester 0 has first priority after reset.
- Requester contract: hold valid, data, parity and mode stable until ready is seen. Deasserting valid before grant withdraws the request legally.
- err_cnt:
  - Saturates at 2^CNT_W-1.
  - clr_cnt has priority over a simultaneous increment; the result is 0 and that error is not counted.
- chk_* hold their last operands while in IDLE; they do not return to 0.

## Timing
- Reset values (cycle after rst edge):
  - req_ready = 0 (forced while rst=1).
  - chk_data = 0, chk_parity = 0, chk_mode = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_error = 0.
  - err_cnt = 0, busy = 0.
  - state = IDLE, last_grant = NREQ-1.
- Latency: handshake at edge E0, chk_* valid after E0, response registered at E1. rsp_valid is high for exactly the one cycle between E1 and E2.
- Throughput: one request per 2 cycles. A new grant may occur in the same IDLE cycle in which rsp_valid is high.
- All NREQ requesters continuously valid: grants run 0,1,2,3,0,... with no starvation. Worst-case wait is 2*NREQ cycles.
- Reset mid-CHECK: the transaction is dropped, no rsp_valid is issued, and the counter clears. The requester has already been handshaken, so it must re-issue.
- rst has priority over clr_cnt and over all FSM activity.

## Test plan
- Reset: hold rst 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, err_cnt=0. The first grant after release goes to requester 0.
- Single request: req 2 sends data 4'b0001, parity 1, mode 0 -> ready[2] pulses once. chk_data=4'b0001 during CHECK. One cycle later: rsp_valid=1, rsp_id=2, rsp_error=0, err_cnt unchanged.
- Error cases:
  - req 1 sends 4'b0001, parity 0, mode 0 -> rsp_error=1, err_cnt=1.
  - Then req 1 sends 4'b0000, parity 0, mode 1 -> rsp_error=1, err_cnt=2.
- Fairness: all 4 requesters valid for 16 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3, each rsp_valid 2 cycles apart. ready is one-hot or zero every cycle.
- Counter edges: with CNT_W=2, drive 5 erroring requests -> err_cnt 1,2,3,3,3. Assert clr_cnt on the same edge as an error response -> err_cnt=0.
- Reset mid-operation: assert rst during CHECK -> no rsp_valid follows, busy=0, and the next grant goes to requester 0.
